// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared types and constants for the memory-access pipeline stage.
//   - OP_NOP / OP_LDR / OP_STR : opcodes that the stage decodes specially.
//   - mem_state_t              : access FSM state (IDLE = 0, ACCESS = 1).
//   - wb_bundle_t              : write-back bundle. The MEM/WB register
//                                uses the same type.
//   - is_mem_op()              : true for opcodes that access data memory.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_LDR = 5'd8;
    localparam logic [4:0] OP_STR = 5'd9;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [8:0]  rd;
        logic [31:0] data;
        logic        wb_en;
    } wb_bundle_t;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/mem_stage_timeout_ctr.sv
// -----------------------------------------------------------------------------
// mem_timeout_ctr
//   8-bit cycle counter that bounds how long a memory access may stay
//   outstanding.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     clr_i       : force the count to 0 (takes priority over en_i)
//     en_i        : advance the count by one
//     expired_o   : count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage between EX/MEM and MEM/WB. ALU ops and NOPs
//   pass through with one-cycle latency. LDR/STR are issued to data memory
//   over a req/ack handshake while the upstream pipeline is stalled.
//   Ports:
//     clk, rst_n                     : clock, synchronous active-low reset
//     valid_in, op_in, rd_in,
//     alu_result_in, store_data_in   : EX/MEM bundle (alu result = address)
//     stall_out                      : hold EX/MEM and earlier stages
//     mem_req, mem_we, mem_addr,
//     mem_wdata, mem_ack, mem_rdata  : data-memory handshake
//     valid_out, wb_en_out, op_out,
//     rd_out, wb_data_out            : registered write-back bundle
//     err_out                        : sticky misalignment/timeout flag
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [4:0]  op_in,
    input  logic [8:0]  rd_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        valid_out,
    output logic        wb_en_out,
    output logic [4:0]  op_out,
    output logic [8:0]  rd_out,
    output logic [31:0] wb_data_out,
    output logic        err_out
);

    mem_state_t  state_q;
    wb_bundle_t  wb_q;
    logic        valid_q;
    logic        err_q;

    // Access latches: held stable for the whole ACCESS state.
    logic [4:0]  op_q;
    logic [8:0]  rd_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        in_access;
    logic        expired;

    assign in_access = (state_q == ACCESS);

    // The counter is cleared whenever the access ends (ack or expiry) and
    // while idle, so each new access starts counting from zero.
    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!in_access || mem_ack || expired),
        .en_i      (in_access),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wb_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (valid_in) begin
                        if (is_mem_op(op_in)) begin
                            if (alu_result_in[1:0] != 2'b00) begin
                                // Misaligned: drop the op as a bubble, no request.
                                err_q <= 1'b1;
                            end else begin
                                op_q    <= op_in;
                                rd_q    <= rd_in;
                                addr_q  <= alu_result_in;
                                wdata_q <= store_data_in;
                                state_q <= ACCESS;
                            end
                        end else begin
                            wb_q <= '{op:    op_in,
                                      rd:    rd_in,
                                      data:  alu_result_in,
                                      wb_en: (op_in != OP_NOP)};
                            valid_q <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        wb_q <= '{op:    op_q,
                                  rd:    rd_q,
                                  data:  (op_q == OP_LDR) ? mem_rdata : addr_q,
                                  wb_en: (op_q == OP_LDR)};
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (expired) begin
                        err_q   <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_out   = in_access;
    assign mem_req     = in_access;
    assign mem_we      = in_access && (op_q == OP_STR);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;

    assign valid_out   = valid_q;
    assign wb_en_out   = wb_q.wb_en;
    assign op_out      = wb_q.op;
    assign rd_out      = wb_q.rd;
    assign wb_data_out = wb_q.data;
    assign err_out     = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Self-checking bench for mem_stage (TIMEOUT = 4). Expected write-back
//   bundles go into a scoreboard queue when stimulus is driven and are
//   popped when valid_out is seen.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam logic [4:0] T_NOP = 5'd0;
    localparam logic [4:0] T_ADD = 5'd3;
    localparam logic [4:0] T_LDR = 5'd8;
    localparam logic [4:0] T_STR = 5'd9;

    typedef struct packed {
        logic [4:0]  op;
        logic [8:0]  rd;
        logic [31:0] data;
        logic        wb_en;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [4:0]  op_in = '0;
    logic [8:0]  rd_in = '0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] store_data_in = '0;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        valid_out;
    logic        wb_en_out;
    logic [4:0]  op_out;
    logic [8:0]  rd_out;
    logic [31:0] wb_data_out;
    logic        err_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last_exp;

    mem_stage #(
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .op_in         (op_in),
        .rd_in         (rd_in),
        .alu_result_in (alu_result_in),
        .store_data_in (store_data_in),
        .stall_out     (stall_out),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .valid_out     (valid_out),
        .wb_en_out     (wb_en_out),
        .op_out        (op_out),
        .rd_out        (rd_out),
        .wb_data_out   (wb_data_out),
        .err_out       (err_out)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [8:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd);
        valid_in      = v;
        op_in         = op;
        rd_in         = rd;
        alu_result_in = alu;
        store_data_in = sd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        tick();
        tick();
        checks++;
        if ({stall_out, mem_req, mem_we, mem_addr, mem_wdata, valid_out, wb_en_out,
             op_out, rd_out, wb_data_out, err_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b req=%b we=%b addr=%h wdata=%h v=%b wben=%b op=%h rd=%h wb=%h err=%b, want all 0",
                     stall_out, mem_req, mem_we, mem_addr, mem_wdata, valid_out, wb_en_out,
                     op_out, rd_out, wb_data_out, err_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        exp_t e;
        sb.push_back('{op: T_ADD, rd: 9'h012, data: 32'h0000_00FF, wb_en: 1'b1});
        drive(1'b1, T_ADD, 9'h012, 32'h0000_00FF, 32'h0);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        checks++;
        if (valid_out !== 1'b1 || stall_out !== 1'b0 || sb.size() == 0) begin
            errors++;
            $display("FAIL alu_valid: got valid=%b stall=%b, want valid=1 stall=0", valid_out, stall_out);
        end else begin
            e = sb.pop_front();
            last_exp = e;
            checks++;
            if ({op_out, rd_out, wb_data_out, wb_en_out} !== {e.op, e.rd, e.data, e.wb_en}) begin
                errors++;
                $display("FAIL alu_bundle: got op=%h rd=%h data=%h wben=%b, want op=%h rd=%h data=%h wben=%b",
                         op_out, rd_out, wb_data_out, wb_en_out, e.op, e.rd, e.data, e.wb_en);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ops  [3] = '{T_ADD, T_NOP, 5'd31};
        logic [31:0] vals [3] = '{32'hA5A5_0001, 32'h0BAD_F00D, 32'hFFFF_FFFF};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{op: ops[i], rd: 9'(i + 1), data: vals[i], wb_en: (ops[i] != T_NOP)});
            drive(1'b1, ops[i], 9'(i + 1), vals[i], 32'h0);
            tick();
            checks++;
            if (valid_out !== 1'b1 || sb.size() == 0) begin
                errors++;
                $display("FAIL b2b_valid[%0d]: got valid=%b, want 1", i, valid_out);
            end else begin
                e = sb.pop_front();
                last_exp = e;
                checks++;
                if ({op_out, rd_out, wb_data_out, wb_en_out} !== {e.op, e.rd, e.data, e.wb_en}) begin
                    errors++;
                    $display("FAIL b2b_bundle[%0d]: got op=%h rd=%h data=%h wben=%b, want op=%h rd=%h data=%h wben=%b",
                             i, op_out, rd_out, wb_data_out, wb_en_out, e.op, e.rd, e.data, e.wb_en);
                end
            end
        end
        drive(1'b0, T_ADD, 9'h1FF, 32'h1111_1111, 32'h0);
        tick();
        checks++;
        if (valid_out !== 1'b0 ||
            {op_out, rd_out, wb_data_out, wb_en_out} !== {last_exp.op, last_exp.rd, last_exp.data, last_exp.wb_en}) begin
            errors++;
            $display("FAIL idle_hold: got valid=%b op=%h rd=%h data=%h wben=%b, want valid=0 and held op=%h rd=%h data=%h",
                     valid_out, op_out, rd_out, wb_data_out, wb_en_out, last_exp.op, last_exp.rd, last_exp.data);
        end
    endtask

    task automatic test_load();
        int   stall_cnt = 0;
        int   req_cnt = 0;
        bit   got = 0;
        exp_t e;
        sb.push_back('{op: T_LDR, rd: 9'h005, data: 32'hDEAD_BEEF, wb_en: 1'b1});
        drive(1'b1, T_LDR, 9'h005, 32'h0000_0100, 32'h0);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL ldr_issue: got req=%b we=%b addr=%h, want req=1 we=0 addr=00000100",
                     mem_req, mem_we, mem_addr);
        end
        for (int c = 0; c < 20 && !got; c++) begin
            if (valid_out) begin
                got = 1;
            end else begin
                if (stall_out) stall_cnt++;
                if (mem_req) req_cnt++;
                mem_ack   = mem_req && (req_cnt == 3);
                mem_rdata = mem_ack ? 32'hDEAD_BEEF : 32'h0;
                tick();
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
            end
        end
        checks++;
        if (!got || stall_cnt != 3 || stall_out !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL ldr_timing: got seen=%0d stall_cycles=%0d stall=%b req=%b, want seen=1 stall_cycles=3 stall=0 req=0",
                     got, stall_cnt, stall_out, mem_req);
        end
        if (got && sb.size() != 0) begin
            e = sb.pop_front();
            last_exp = e;
            checks++;
            if ({op_out, rd_out, wb_data_out, wb_en_out} !== {e.op, e.rd, e.data, e.wb_en}) begin
                errors++;
                $display("FAIL ldr_bundle: got op=%h rd=%h data=%h wben=%b, want op=%h rd=%h data=%h wben=%b",
                         op_out, rd_out, wb_data_out, wb_en_out, e.op, e.rd, e.data, e.wb_en);
            end
        end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL ldr_pulse: got valid=%b one cycle after, want 0", valid_out);
        end
    endtask

    task automatic test_store();
        exp_t e;
        sb.push_back('{op: T_STR, rd: 9'h007, data: 32'h0000_0104, wb_en: 1'b0});
        drive(1'b1, T_STR, 9'h007, 32'h0000_0104, 32'h1234_5678);
        tick();
        // valid_in is ignored during ACCESS; keep a junk op present.
        drive(1'b1, T_ADD, 9'h0AA, 32'h7777_7777, 32'h0);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h104) begin
            errors++;
            $display("FAIL str_issue: got req=%b we=%b addr=%h wdata=%h, want req=1 we=1 addr=00000104 wdata=12345678",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        checks++;
        if (valid_out !== 1'b1 || mem_we !== 1'b0 || mem_req !== 1'b0 || sb.size() == 0) begin
            errors++;
            $display("FAIL str_done: got valid=%b we=%b req=%b, want valid=1 we=0 req=0", valid_out, mem_we, mem_req);
        end else begin
            e = sb.pop_front();
            last_exp = e;
            checks++;
            if ({op_out, rd_out, wb_data_out, wb_en_out} !== {e.op, e.rd, e.data, e.wb_en}) begin
                errors++;
                $display("FAIL str_bundle: got op=%h rd=%h data=%h wben=%b, want op=%h rd=%h data=%h wben=%b",
                         op_out, rd_out, wb_data_out, wb_en_out, e.op, e.rd, e.data, e.wb_en);
            end
        end
        tick();
        checks++;
        if (valid_out !== 1'b0 || err_out !== 1'b0) begin
            errors++;
            $display("FAIL str_after: got valid=%b err=%b, want valid=0 err=0", valid_out, err_out);
        end
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        bit done = 0;
        drive(1'b1, T_LDR, 9'h033, 32'h0000_0200, 32'h0);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        for (int c = 0; c < 20 && !done; c++) begin
            if (!mem_req) begin
                done = 1;
            end else begin
                req_cnt++;
                checks++;
                if (valid_out !== 1'b0 || stall_out !== 1'b1 || err_out !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_wait[%0d]: got valid=%b stall=%b err=%b, want valid=0 stall=1 err=0",
                             c, valid_out, stall_out, err_out);
                end
                tick();
            end
        end
        checks++;
        if (!done || req_cnt != 4 || err_out !== 1'b1 || valid_out !== 1'b0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_end: got ended=%0d req_cycles=%0d err=%b valid=%b stall=%b, want ended=1 req_cycles=4 err=1 valid=0 stall=0",
                     done, req_cnt, err_out, valid_out, stall_out);
        end
    endtask

    task automatic test_reset_mid_access();
        drive(1'b1, T_LDR, 9'h044, 32'h0000_0300, 32'h0);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got req=%b in 2nd access cycle, want 1", mem_req);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({stall_out, mem_req, mem_we, mem_addr, mem_wdata, valid_out, wb_en_out,
             op_out, rd_out, wb_data_out, err_out} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got stall=%b req=%b we=%b addr=%h wdata=%h v=%b wben=%b op=%h rd=%h wb=%h err=%b, want all 0",
                     stall_out, mem_req, mem_we, mem_addr, mem_wdata, valid_out, wb_en_out,
                     op_out, rd_out, wb_data_out, err_out);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (valid_out !== 1'b0 || mem_req !== 1'b0 || wb_data_out !== 32'h0 || stall_out !== 1'b0) begin
                errors++;
                $display("FAIL late_ack[%0d]: got valid=%b req=%b wb=%h stall=%b, want 0 0 00000000 0",
                         i, valid_out, mem_req, wb_data_out, stall_out);
            end
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic test_misaligned();
        exp_t e;
        drive(1'b1, T_LDR, 9'h055, 32'h0000_0102, 32'h0);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        checks++;
        if (mem_req !== 1'b0 || stall_out !== 1'b0 || valid_out !== 1'b0 || err_out !== 1'b1) begin
            errors++;
            $display("FAIL misaligned: got req=%b stall=%b valid=%b err=%b, want req=0 stall=0 valid=0 err=1",
                     mem_req, stall_out, valid_out, err_out);
        end
        sb.push_back('{op: T_ADD, rd: 9'h020, data: 32'h0000_0055, wb_en: 1'b1});
        drive(1'b1, T_ADD, 9'h020, 32'h0000_0055, 32'h0);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        checks++;
        if (valid_out !== 1'b1 || err_out !== 1'b1 || mem_req !== 1'b0 || sb.size() == 0) begin
            errors++;
            $display("FAIL misaligned_next: got valid=%b err=%b req=%b, want valid=1 err=1 req=0",
                     valid_out, err_out, mem_req);
        end else begin
            e = sb.pop_front();
            checks++;
            if ({op_out, rd_out, wb_data_out, wb_en_out} !== {e.op, e.rd, e.data, e.wb_en}) begin
                errors++;
                $display("FAIL misaligned_next_bundle: got op=%h rd=%h data=%h wben=%b, want op=%h rd=%h data=%h wben=%b",
                         op_out, rd_out, wb_data_out, wb_en_out, e.op, e.rd, e.data, e.wb_en);
            end
        end
        tick();
        tick();
        checks++;
        if (err_out !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got err=%b, want 1", err_out);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_timeout();
        test_reset_mid_access();
        test_misaligned();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
